// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the hazard/sequencing controller:
// pipeline-register mode encodings and MDU sequencer states.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_FLUSH  = 2'b01,
        MODE_STALL  = 2'b10
    } mode_e;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MDU_BUSY = 1'b1
    } state_e;

    function automatic logic reg_match(
        input logic       used,
        input logic [4:0] rs,
        input logic [4:0] rd
    );
        return used && (rs == rd);
    endfunction

endpackage

// File: rtl/hazard_ctrl_mdu_timer.sv
// MDU occupancy sequencer: loads MDU_LAT-1 on an accepted start,
// counts down, and reports busy (holding) / done (release cycle).
module hazard_ctrl_mdu_timer #(
    parameter int MDU_LAT = 32
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_dmem_busy,
    output logic o_busy,
    output logic o_done
);
    import hazard_ctrl_pkg::*;

    localparam int CW = $clog2(MDU_LAT + 1);
    localparam logic [CW-1:0] LOAD = CW'(MDU_LAT - 1);

    state_e        r_state;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_RUN;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                ST_RUN: begin
                    // a frozen EX re-presents the start, so refuse it now
                    if (i_start && !i_dmem_busy) begin
                        r_state <= ST_MDU_BUSY;
                        r_cnt   <= LOAD;
                    end
                end
                ST_MDU_BUSY: begin
                    if (r_cnt != '0)
                        r_cnt <= r_cnt - CW'(1);
                    else
                        r_state <= ST_RUN;
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    assign o_busy = (r_state == ST_MDU_BUSY) && (r_cnt != '0);
    assign o_done = (r_state == ST_MDU_BUSY) && (r_cnt == '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: priority-resolved stage modes,
// PC stall and a saturating stall-cycle perf counter.
module hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int MDU_LAT    = 32,
    parameter int CNT_W      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [REG_ADDR_W-1:0] id_rs1_i,
    input  logic [REG_ADDR_W-1:0] id_rs2_i,
    input  logic                  id_rs1_used_i,
    input  logic                  id_rs2_used_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic                  ex_mem_read_i,
    input  logic                  ex_redirect_i,
    input  logic                  ex_mdu_start_i,
    input  logic                  imem_busy_i,
    input  logic                  dmem_busy_i,
    output logic                  pc_stall_o,
    output logic [1:0]            if_id_mode_o,
    output logic [1:0]            id_ex_mode_o,
    output logic [1:0]            ex_mem_mode_o,
    output logic [1:0]            mem_wb_mode_o,
    output logic [CNT_W-1:0]      stall_cycles_o
);
    import hazard_ctrl_pkg::*;

    logic       w_mdu_busy;
    logic       w_mdu_done;
    logic       w_mdu_run;
    logic       w_hold;
    logic       w_redir;
    logic       w_lduse;
    logic       w_pc_stall;
    mode_e      w_if_id;
    mode_e      w_id_ex;
    mode_e      w_ex_mem;
    mode_e      w_mem_wb;
    logic [CNT_W-1:0] r_stall_cnt;

    hazard_ctrl_mdu_timer #(
        .MDU_LAT(MDU_LAT)
    ) u_mdu_timer (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_start     (ex_mdu_start_i),
        .i_dmem_busy (dmem_busy_i),
        .o_busy      (w_mdu_busy),
        .o_done      (w_mdu_done)
    );

    assign w_mdu_run = !(w_mdu_busy || w_mdu_done);
    assign w_hold    = (w_mdu_run && ex_mdu_start_i) || w_mdu_busy;
    // EX still holds the MDU op while sequencing, so a redirect is bogus
    assign w_redir   = ex_redirect_i && w_mdu_run;
    assign w_lduse   = ex_mem_read_i && (ex_rd_i != '0) &&
                       (reg_match(id_rs1_used_i, id_rs1_i, ex_rd_i) ||
                        reg_match(id_rs2_used_i, id_rs2_i, ex_rd_i));

    always_comb begin
        w_pc_stall = 1'b0;
        w_if_id    = MODE_NORMAL;
        w_id_ex    = MODE_NORMAL;
        w_ex_mem   = MODE_NORMAL;
        w_mem_wb   = MODE_NORMAL;
        if (rst_i) begin
            w_if_id  = MODE_FLUSH;
            w_id_ex  = MODE_FLUSH;
            w_ex_mem = MODE_FLUSH;
            w_mem_wb = MODE_FLUSH;
        end else if (dmem_busy_i) begin
            w_pc_stall = 1'b1;
            w_if_id    = MODE_STALL;
            w_id_ex    = MODE_STALL;
            w_ex_mem   = MODE_STALL;
            w_mem_wb   = MODE_FLUSH;
        end else if (w_hold) begin
            w_pc_stall = 1'b1;
            w_if_id    = MODE_STALL;
            w_id_ex    = MODE_STALL;
            w_ex_mem   = MODE_FLUSH;
        end else if (w_redir) begin
            w_if_id = MODE_FLUSH;
            w_id_ex = MODE_FLUSH;
        end else if (w_lduse) begin
            w_pc_stall = 1'b1;
            w_if_id    = MODE_STALL;
            w_id_ex    = MODE_FLUSH;
        end else if (imem_busy_i) begin
            w_pc_stall = 1'b1;
            w_if_id    = MODE_FLUSH;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_stall_cnt <= '0;
        else if (w_pc_stall && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign pc_stall_o     = w_pc_stall;
    assign if_id_mode_o   = w_if_id;
    assign id_ex_mode_o   = w_id_ex;
    assign ex_mem_mode_o  = w_ex_mem;
    assign mem_wb_mode_o  = w_mem_wb;
    assign stall_cycles_o = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a cycle model pushes expected
// modes/count per driven cycle, a negedge monitor pops and compares.
module tb_hazard_ctrl;

    localparam int LAT = 4;
    localparam int CW  = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [4:0]    rs1, rs2, rd;
    logic          u1, u2, mrd, redir, start, imem, dmem;
    logic          pc_stall;
    logic [1:0]    m_ifid, m_idex, m_exmem, m_memwb;
    logic [CW-1:0] scnt;

    typedef struct {
        string      tag;
        logic [8:0] modes;
        logic [3:0] cnt;
        bit         ccnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_run  = 0;
    int   n_fail = 0;

    int   m_cyc = 0;
    int   m_t   = 0;
    bit   m_act = 0;
    int   m_cnt = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .REG_ADDR_W(5),
        .MDU_LAT   (LAT),
        .CNT_W     (CW)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .id_rs1_i       (rs1),
        .id_rs2_i       (rs2),
        .id_rs1_used_i  (u1),
        .id_rs2_used_i  (u2),
        .ex_rd_i        (rd),
        .ex_mem_read_i  (mrd),
        .ex_redirect_i  (redir),
        .ex_mdu_start_i (start),
        .imem_busy_i    (imem),
        .dmem_busy_i    (dmem),
        .pc_stall_o     (pc_stall),
        .if_id_mode_o   (m_ifid),
        .id_ex_mode_o   (m_idex),
        .ex_mem_mode_o  (m_exmem),
        .mem_wb_mode_o  (m_memwb),
        .stall_cycles_o (scnt)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check({e.tag, "/modes"},
                  {23'd0, pc_stall, m_ifid, m_idex, m_exmem, m_memwb},
                  {23'd0, e.modes});
            if (e.ccnt)
                check({e.tag, "/cnt"}, {28'd0, scnt}, {28'd0, e.cnt});
        end
    end

    // one cycle: drive, predict, hand the prediction to the monitor
    task automatic cyc(input string tag, input logic r,
                       input logic [4:0] a1, input logic [4:0] a2,
                       input logic v1, input logic v2,
                       input logic [4:0] d, input logic ld,
                       input logic rdr, input logic st,
                       input logic im, input logic dm);
        exp_t e;
        bit   inbusy, hold, lu, ps;
        logic [1:0] f, i, x, w;
        rst = r; rs1 = a1; rs2 = a2; u1 = v1; u2 = v2;
        rd = d; mrd = ld; redir = rdr; start = st;
        imem = im; dmem = dm;
        inbusy = m_act && (m_cyc >= m_t + 1) && (m_cyc <= m_t + LAT);
        hold   = (m_act && (m_cyc >= m_t + 1) && (m_cyc <= m_t + LAT - 1))
                 || (!inbusy && st);
        lu     = ld && (d != 5'd0) &&
                 ((v1 && a1 == d) || (v2 && a2 == d));
        assert (r || !(rdr && inbusy))
            else $error("redirect while MDU sequencing");
        ps = 0; f = 2'b00; i = 2'b00; x = 2'b00; w = 2'b00;
        if (r) begin
            f = 2'b01; i = 2'b01; x = 2'b01; w = 2'b01;
        end else if (dm) begin
            ps = 1; f = 2'b10; i = 2'b10; x = 2'b10; w = 2'b01;
        end else if (hold) begin
            ps = 1; f = 2'b10; i = 2'b10; x = 2'b01;
        end else if (rdr && !inbusy) begin
            f = 2'b01; i = 2'b01;
        end else if (lu) begin
            ps = 1; f = 2'b10; i = 2'b01;
        end else if (im) begin
            ps = 1; f = 2'b01;
        end
        e.tag   = tag;
        e.modes = {ps, f, i, x, w};
        e.cnt   = 4'(m_cnt);
        e.ccnt  = !r;
        exp_q.push_back(e);
        @(posedge clk);
        if (r) begin
            m_act = 0;
            m_cnt = 0;
        end else begin
            if (!inbusy && st && !dm) begin
                m_act = 1;
                m_t   = m_cyc;
            end
            if (ps && m_cnt < 15)
                m_cnt++;
        end
        m_cyc++;
        #1;
    endtask

    task automatic idle(input string tag, input logic r);
        cyc(tag, r, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0, 0);
    endtask

    task automatic mdu(input string tag, input logic st, input logic dm);
        cyc(tag, 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, st, 0, dm);
    endtask

    initial begin
        rst = 1; rs1 = 0; rs2 = 0; u1 = 0; u2 = 0; rd = 0;
        mrd = 0; redir = 0; start = 0; imem = 0; dmem = 0;
        @(posedge clk);
        #1;
        idle("T1rst", 1);
        idle("T1rst", 1);
        idle("T1run", 0);
        idle("T1run", 0);

        cyc("T2lu", 0, 5'd1, 5'd5, 0, 1, 5'd5, 1, 0, 0, 0, 0);
        idle("T2after", 0);
        cyc("T2rd0", 0, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0, 0, 0);
        cyc("T2unused", 0, 5'd7, 5'd3, 0, 1, 5'd7, 1, 0, 0, 0, 0);
        cyc("T2rs1", 0, 5'd9, 5'd3, 1, 0, 5'd9, 1, 0, 0, 0, 0);
        cyc("T2noload", 0, 5'd9, 5'd3, 1, 0, 5'd9, 0, 0, 0, 0, 0);

        cyc("T3redlu", 0, 5'd5, 5'd5, 1, 1, 5'd5, 1, 1, 0, 0, 0);
        cyc("T3redim", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 1, 0);
        cyc("T3im", 0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 1, 0);

        idle("T4rst", 1);
        for (int k = 0; k <= LAT; k++)
            mdu($sformatf("T4mdu%0d", k), 1, 0);
        idle("T4rel", 0);
        idle("T4rel", 0);

        mdu("T5mdu0", 1, 0);
        for (int k = 1; k <= 3; k++)
            mdu($sformatf("T5dm%0d", k), 1, 1);
        mdu("T5mdu4", 1, 0);
        idle("T5rel", 0);
        mdu("T5startdm", 1, 1);
        for (int k = 0; k <= LAT; k++)
            mdu($sformatf("T5late%0d", k), 1, 0);
        idle("T5rel2", 0);

        idle("T6rst", 1);
        for (int k = 0; k < 20; k++)
            cyc($sformatf("T6im%0d", k), 0, 5'd0, 5'd0, 0, 0, 5'd0,
                0, 0, 0, 1, 0);
        idle("T6sat", 0);
        mdu("T6mdu0", 1, 0);
        mdu("T6mdu1", 1, 0);
        cyc("T6rstmid", 1, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0, 0);
        idle("T6norm", 0);
        idle("T6norm", 0);

        @(negedge clk);
        #1;
        check("q_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
